// File: rtl/amber48_pkg.sv
// Shared amber48 execute-stage types for the multi-cycle multiply/divide unit:
// op encoding, FSM states and operand-sign helpers.
package amber48_pkg;

   typedef enum logic [2:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHSU = 3'd2,
      OP_MULHU  = 3'd3,
      OP_DIV    = 3'd4,
      OP_DIVU   = 3'd5,
      OP_REM    = 3'd6,
      OP_REMU   = 3'd7
   } muldiv_op_e;

   typedef enum logic [1:0] {
      MD_IDLE  = 2'd0,
      MD_BUSY  = 2'd1,
      MD_FINAL = 2'd2,
      MD_DONE  = 2'd3
   } muldiv_state_e;

   localparam int unsigned MULDIV_BPC_DEFAULT = 1;

   function automatic logic is_div(input muldiv_op_e op);
      return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
   endfunction

   function automatic logic is_rem(input muldiv_op_e op);
      return op inside {OP_REM, OP_REMU};
   endfunction

   // Operand a is two's complement for these ops (MUL low half is sign-agnostic).
   function automatic logic signed_a(input muldiv_op_e op);
      return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
   endfunction

   function automatic logic signed_b(input muldiv_op_e op);
      return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
   endfunction

endpackage

// File: rtl/amber48_muldiv_iter.sv
// One combinational iteration of the muldiv datapath: BPC shift-add (multiply)
// or restoring shift-subtract (divide) steps over the {hi, lo} working pair.
module amber48_muldiv_iter #(
   parameter int unsigned XLEN = 48,
   parameter int unsigned BPC  = 1
) (
   input  logic            div_i,
   input  logic [XLEN-1:0] hi_i,
   input  logic [XLEN-1:0] lo_i,
   input  logic [XLEN-1:0] opnd_i,
   output logic [XLEN-1:0] hi_o,
   output logic [XLEN-1:0] lo_o
);

   always_comb begin : step_b
      logic [XLEN-1:0] hi;
      logic [XLEN-1:0] lo;
      logic [XLEN:0]   sum;
      hi  = hi_i;
      lo  = lo_i;
      sum = '0;
      for (int unsigned s = 0; s < BPC; s++) begin
         if (div_i) begin
            // Partial remainder stays below the divisor, so bit XLEN is the borrow.
            sum = {hi, lo[XLEN-1]} - {1'b0, opnd_i};
            if (!sum[XLEN]) begin
               hi = sum[XLEN-1:0];
               lo = {lo[XLEN-2:0], 1'b1};
            end else begin
               hi = {hi[XLEN-2:0], lo[XLEN-1]};
               lo = {lo[XLEN-2:0], 1'b0};
            end
         end else begin
            sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd_i} : {(XLEN+1){1'b0}});
            hi  = sum[XLEN:1];
            lo  = {sum[0], lo[XLEN-1:1]};
         end
      end
      hi_o = hi;
      lo_o = lo;
   end

endmodule

// File: rtl/amber48_muldiv_unit.sv
// amber48 multi-cycle integer multiply/divide unit with valid/ready handshakes.
// Define AMBER48_MULDIV_FAST_MUL_EN for single-cycle combinational multiplies.
module amber48_muldiv_unit
   import amber48_pkg::*;
#(
   parameter int unsigned XLEN           = 48,
   parameter int unsigned BITS_PER_CYCLE = MULDIV_BPC_DEFAULT,
   parameter int unsigned TAG_W          = 5
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [2:0]       req_op_i,
   input  logic [XLEN-1:0]  req_a_i,
   input  logic [XLEN-1:0]  req_b_i,
   input  logic [TAG_W-1:0] req_tag_i,
   output logic             resp_valid_o,
   input  logic             resp_ready_i,
   output logic [XLEN-1:0]  resp_result_o,
   output logic [TAG_W-1:0] resp_tag_o,
   output logic             busy_o
);

   localparam int unsigned ITER  = XLEN / BITS_PER_CYCLE;
   localparam int unsigned CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
   localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

   if (!(BITS_PER_CYCLE inside {1, 2, 4}) || (XLEN % BITS_PER_CYCLE) != 0) begin : g_bad_bpc
      $error("amber48_muldiv_unit: BITS_PER_CYCLE must be 1, 2 or 4 and divide XLEN");
   end

   muldiv_state_e    state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   muldiv_op_e       op_q, op_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [XLEN-1:0]  hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
   logic [XLEN-1:0]  result_q, result_d;
   logic             neg_q, neg_d, valid_q, valid_d;

   muldiv_op_e        req_op;
   logic              accept_c, a_neg_c, b_neg_c;
   logic [XLEN-1:0]   a_mag_c, b_mag_c;
   logic              div_zero_c, div_ovf_c, special_c;
   logic [XLEN-1:0]   special_res_c;
   logic              fast_c;
   logic [XLEN-1:0]   fast_res_c;
   logic [XLEN-1:0]   iter_hi_c, iter_lo_c;
   logic [2*XLEN-1:0] prod_c;
   logic [XLEN-1:0]   div_val_c, div_res_c, final_res_c;

   assign req_op      = muldiv_op_e'(req_op_i);
   assign req_ready_o = !flush_i && (state_q == MD_IDLE || (state_q == MD_DONE && resp_ready_i));
   assign accept_c    = req_valid_i && req_ready_o;

   // Operands are iterated as unsigned magnitudes; the sign is restored in FINAL.
   assign a_neg_c = signed_a(req_op) && req_a_i[XLEN-1];
   assign b_neg_c = signed_b(req_op) && req_b_i[XLEN-1];
   assign a_mag_c = a_neg_c ? -req_a_i : req_a_i;
   assign b_mag_c = b_neg_c ? -req_b_i : req_b_i;

   assign div_zero_c    = (req_b_i == '0);
   assign div_ovf_c     = (req_op == OP_DIV || req_op == OP_REM) && (req_a_i == XMIN) && (&req_b_i);
   assign special_c     = is_div(req_op) && (div_zero_c || div_ovf_c);
   assign special_res_c = div_zero_c ? (is_rem(req_op) ? req_a_i : '1)
                                     : (is_rem(req_op) ? '0 : XMIN);

`ifdef AMBER48_MULDIV_FAST_MUL_EN
   logic [2*XLEN-1:0] fast_a_c, fast_b_c, fast_prod_c;
   assign fast_a_c    = {{XLEN{signed_a(req_op) & req_a_i[XLEN-1]}}, req_a_i};
   assign fast_b_c    = {{XLEN{signed_b(req_op) & req_b_i[XLEN-1]}}, req_b_i};
   assign fast_prod_c = fast_a_c * fast_b_c;
   assign fast_res_c  = (req_op == OP_MUL) ? fast_prod_c[XLEN-1:0] : fast_prod_c[2*XLEN-1:XLEN];
   assign fast_c      = !is_div(req_op);
`else
   assign fast_res_c  = '0;
   assign fast_c      = 1'b0;
`endif

   amber48_muldiv_iter #(
      .XLEN (XLEN),
      .BPC  (BITS_PER_CYCLE)
   ) u_iter (
      .div_i  (is_div(op_q)),
      .hi_i   (hi_q),
      .lo_i   (lo_q),
      .opnd_i (opnd_q),
      .hi_o   (iter_hi_c),
      .lo_o   (iter_lo_c)
   );

   // After the last step: hi/lo hold product halves, or remainder/quotient.
   assign prod_c      = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
   assign div_val_c   = is_rem(op_q) ? hi_q : lo_q;
   assign div_res_c   = neg_q ? -div_val_c : div_val_c;
   assign final_res_c = is_div(op_q) ? div_res_c
                      : (op_q == OP_MUL) ? prod_c[XLEN-1:0] : prod_c[2*XLEN-1:XLEN];

   always_comb begin : next_b
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      tag_d    = tag_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      opnd_d   = opnd_q;
      neg_d    = neg_q;
      result_d = result_q;
      valid_d  = valid_q;

      case (state_q)
         MD_BUSY: begin
            hi_d  = iter_hi_c;
            lo_d  = iter_lo_c;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == '0) state_d = MD_FINAL;
         end
         MD_FINAL: begin
            result_d = final_res_c;
            valid_d  = 1'b1;
            state_d  = MD_DONE;
         end
         MD_DONE: begin
            if (resp_ready_i) begin
               valid_d = 1'b0;
               state_d = MD_IDLE;
            end
         end
         default: ;
      endcase

      // A new accept overrides the DONE->IDLE retirement for back-to-back ops.
      if (accept_c) begin
         op_d  = req_op;
         tag_d = req_tag_i;
         cnt_d = CNT_W'(ITER - 1);
         hi_d  = '0;
         if (is_div(req_op)) begin
            lo_d   = a_mag_c;
            opnd_d = b_mag_c;
            neg_d  = is_rem(req_op) ? a_neg_c : (a_neg_c ^ b_neg_c);
         end else begin
            lo_d   = b_mag_c;
            opnd_d = a_mag_c;
            neg_d  = a_neg_c ^ b_neg_c;
         end
         if (special_c) begin
            result_d = special_res_c;
            valid_d  = 1'b1;
            state_d  = MD_DONE;
         end else if (fast_c) begin
            result_d = fast_res_c;
            valid_d  = 1'b1;
            state_d  = MD_DONE;
         end else begin
            valid_d  = 1'b0;
            state_d  = MD_BUSY;
         end
      end

      if (flush_i) begin
         state_d = MD_IDLE;
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= MD_IDLE;
         cnt_q    <= '0;
         op_q     <= OP_MUL;
         tag_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         opnd_q   <= '0;
         neg_q    <= 1'b0;
         result_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         tag_q    <= tag_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         opnd_q   <= opnd_d;
         neg_q    <= neg_d;
         result_q <= result_d;
         valid_q  <= valid_d;
      end
   end

   assign resp_valid_o  = valid_q;
   assign resp_result_o = result_q;
   assign resp_tag_o    = tag_q;
   assign busy_o        = (state_q != MD_IDLE);

endmodule

// File: tb/tb_amber48_muldiv_unit.sv
// Bench for amber48_muldiv_unit: directed and random ops on a 1-bit/cycle and a
// 4-bit/cycle instance, checked against an arithmetic reference model.
module tb_amber48_muldiv_unit;
   import amber48_pkg::*;

   localparam logic [47:0] XMIN = 48'h8000_0000_0000;

   logic        clk, rst_n;
   logic        flush [2];
   logic        req_valid [2];
   logic        req_ready [2];
   logic [2:0]  req_op [2];
   logic [47:0] req_a [2];
   logic [47:0] req_b [2];
   logic [4:0]  req_tag [2];
   logic        resp_valid [2];
   logic        resp_ready [2];
   logic [47:0] resp_result [2];
   logic [4:0]  resp_tag [2];
   logic        busy [2];

   int n_assert = 0;
   int n_fail   = 0;

   amber48_muldiv_unit #(.XLEN(48), .BITS_PER_CYCLE(1), .TAG_W(5)) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[0]),
      .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_op_i(req_op[0]),
      .req_a_i(req_a[0]), .req_b_i(req_b[0]), .req_tag_i(req_tag[0]),
      .resp_valid_o(resp_valid[0]), .resp_ready_i(resp_ready[0]),
      .resp_result_o(resp_result[0]), .resp_tag_o(resp_tag[0]), .busy_o(busy[0]));

   amber48_muldiv_unit #(.XLEN(48), .BITS_PER_CYCLE(4), .TAG_W(5)) u_dut4 (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[1]),
      .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_op_i(req_op[1]),
      .req_a_i(req_a[1]), .req_b_i(req_b[1]), .req_tag_i(req_tag[1]),
      .resp_valid_o(resp_valid[1]), .resp_ready_i(resp_ready[1]),
      .resp_result_o(resp_result[1]), .resp_tag_o(resp_tag[1]), .busy_o(busy[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference result straight from the arithmetic definition of each op.
   function automatic logic [47:0] mdl(input muldiv_op_e op, input logic [47:0] a, input logic [47:0] b);
      logic [95:0] ea, eb, p;
      logic signed [47:0] sa, sb;
      logic ovf;
      ea = {48'd0, a};
      eb = {48'd0, b};
      if (op == OP_MULH || op == OP_MULHSU) ea = {{48{a[47]}}, a};
      if (op == OP_MULH) eb = {{48{b[47]}}, b};
      p   = ea * eb;
      sa  = a;
      sb  = b;
      ovf = (a == XMIN) && (b == 48'hFFFF_FFFF_FFFF);
      case (op)
         OP_MUL:                       return p[47:0];
         OP_MULH, OP_MULHSU, OP_MULHU: return p[95:48];
         OP_DIVU:                      return (b == 0) ? 48'hFFFF_FFFF_FFFF : a / b;
         OP_REMU:                      return (b == 0) ? a : a % b;
         OP_DIV:                       return (b == 0) ? 48'hFFFF_FFFF_FFFF : ovf ? XMIN : 48'(sa / sb);
         default:                      return (b == 0) ? a : ovf ? 48'd0 : 48'(sa % sb);
      endcase
   endfunction

   // Clock edges from the accept edge (inclusive) until resp_valid is seen.
   function automatic int exp_lat(input int u, input muldiv_op_e op, input logic [47:0] a, input logic [47:0] b);
      logic dv;
      dv = op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
      if (dv && (b == 0 || ((op == OP_DIV || op == OP_REM) && a == XMIN && b == 48'hFFFF_FFFF_FFFF)))
         return 1;
`ifdef AMBER48_MULDIV_FAST_MUL_EN
      if (!dv) return 1;
`endif
      return ((u == 0) ? 48 : 12) + 2;
   endfunction

   function automatic logic [47:0] rnd_opnd();
      case ($urandom_range(0, 5))
         0:       return 48'd0;
         1:       return 48'hFFFF_FFFF_FFFF;
         2:       return XMIN;
         3:       return 48'($urandom_range(0, 20));
         default: return 48'({$urandom(), $urandom()});
      endcase
   endfunction

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
      end
   endtask

   task automatic issue(input int u, input muldiv_op_e op, input logic [47:0] a, input logic [47:0] b,
                        input logic [4:0] tag);
      req_op[u]    = 3'(op);
      req_a[u]     = a;
      req_b[u]     = b;
      req_tag[u]   = tag;
      req_valid[u] = 1'b1;
   endtask

   // Called #1 after the accept edge; bounded wait for the response.
   task automatic wait_resp(input int u, input int lat, input logic [47:0] res, input logic [4:0] tag);
      int n;
      n = 1;
      while (!resp_valid[u] && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      chk("latency", 64'(n), 64'(lat));
      chk("result", 64'(resp_result[u]), 64'(res));
      chk("tag", 64'(resp_tag[u]), 64'(tag));
   endtask

   task automatic drain(input int u);
      resp_ready[u] = 1'b1;
      @(posedge clk); #1;
      resp_ready[u] = 1'b0;
      chk("drain_valid", 64'(resp_valid[u]), 64'd0);
      chk("drain_busy", 64'(busy[u]), 64'd0);
   endtask

   task automatic run_op(input int u, input muldiv_op_e op, input logic [47:0] a, input logic [47:0] b,
                         input logic [4:0] tag);
      issue(u, op, a, b, tag);
      #1 chk("req_ready", 64'(req_ready[u]), 64'd1);
      @(posedge clk); #1;
      req_valid[u] = 1'b0;
      wait_resp(u, exp_lat(u, op, a, b), mdl(op, a, b), tag);
      drain(u);
   endtask

   // Flush a long divide k edges into BUSY while a new request is offered.
   task automatic flush_busy(input int u, input int k);
      int seen;
      issue(u, OP_DIVU, 48'h1234_5678_9ABC, 48'd13, 5'd21);
      @(posedge clk); #1;
      req_valid[u] = 1'b0;
      repeat (k) @(posedge clk);
      #1 chk("fl_busy_pre", 64'(busy[u]), 64'd1);
      flush[u] = 1'b1;
      issue(u, OP_DIVU, 48'd5, 48'd0, 5'd22);
      #1 chk("fl_ready", 64'(req_ready[u]), 64'd0);
      @(posedge clk); #1;
      flush[u]     = 1'b0;
      req_valid[u] = 1'b0;
      chk("fl_busy", 64'(busy[u]), 64'd0);
      chk("fl_valid", 64'(resp_valid[u]), 64'd0);
      seen = 0;
      repeat (60) begin
         @(posedge clk); #1;
         if (resp_valid[u] || busy[u]) seen++;
      end
      chk("fl_quiet", 64'(seen), 64'd0);
   endtask

   initial begin
      muldiv_op_e op;
      logic [47:0] a, b;
      rst_n = 1'b0;
      for (int u = 0; u < 2; u++) begin
         flush[u] = 1'b0; req_valid[u] = 1'b0; req_op[u] = '0; req_a[u] = '0;
         req_b[u] = '0; req_tag[u] = '0; resp_ready[u] = 1'b0;
      end
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 64'(resp_valid[0]), 64'd0);
      chk("rst_result", 64'(resp_result[0]), 64'd0);
      chk("rst_tag", 64'(resp_tag[0]), 64'd0);
      chk("rst_busy", 64'(busy[0]), 64'd0);
      chk("rst_ready", 64'(req_ready[0]), 64'd1);
      chk("rst_ready4", 64'(req_ready[1]), 64'd1);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed cases
      run_op(0, OP_DIVU,   48'd100, 48'd7, 5'd3);
      run_op(0, OP_REMU,   48'd100, 48'd7, 5'd3);
      run_op(0, OP_DIV,    48'hFFFF_FFFF_FFF9, 48'd2, 5'd4);
      run_op(0, OP_REM,    48'hFFFF_FFFF_FFF9, 48'd2, 5'd5);
      run_op(0, OP_DIVU,   48'd5, 48'd0, 5'd6);
      run_op(0, OP_REMU,   48'd5, 48'd0, 5'd7);
      run_op(0, OP_DIV,    XMIN, 48'hFFFF_FFFF_FFFF, 5'd8);
      run_op(0, OP_REM,    XMIN, 48'hFFFF_FFFF_FFFF, 5'd9);
      run_op(0, OP_MULHU,  48'hFFFF_FFFF_FFFF, 48'd2, 5'd10);
      run_op(0, OP_MUL,    48'hFFFF_FFFF_FFFF, 48'd2, 5'd11);
      run_op(0, OP_MULH,   48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 5'd12);
      run_op(0, OP_MULHSU, 48'hFFFF_FFFF_FFFF, 48'd3, 5'd13);
      run_op(0, OP_DIVU,   XMIN, 48'hFFFF_FFFF_FFFF, 5'd14);

      // Response held under backpressure, then back-to-back accepts
      issue(0, OP_DIVU, 48'd1000, 48'd9, 5'd7);
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      wait_resp(0, 50, mdl(OP_DIVU, 48'd1000, 48'd9), 5'd7);
      repeat (10) begin
         @(posedge clk); #1;
         chk("hold_valid", 64'(resp_valid[0]), 64'd1);
         chk("hold_result", 64'(resp_result[0]), 64'(mdl(OP_DIVU, 48'd1000, 48'd9)));
         chk("hold_tag", 64'(resp_tag[0]), 64'd7);
      end
      resp_ready[0] = 1'b1;
      issue(0, OP_REMU, 48'd1000, 48'd0, 5'd9);
      #1 chk("b2b_ready", 64'(req_ready[0]), 64'd1);
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      resp_ready[0] = 1'b0;
      chk("b2b_valid", 64'(resp_valid[0]), 64'd1);
      chk("b2b_result", 64'(resp_result[0]), 64'd1000);
      chk("b2b_tag", 64'(resp_tag[0]), 64'd9);
      resp_ready[0] = 1'b1;
      issue(0, OP_MULHU, 48'hDEAD_BEEF_0123, 48'h0F0F_F0F0_1234, 5'd12);
      #1 chk("b2b2_ready", 64'(req_ready[0]), 64'd1);
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      resp_ready[0] = 1'b0;
      wait_resp(0, exp_lat(0, OP_MULHU, 48'hDEAD_BEEF_0123, 48'h0F0F_F0F0_1234),
                mdl(OP_MULHU, 48'hDEAD_BEEF_0123, 48'h0F0F_F0F0_1234), 5'd12);
      drain(0);

      // Flush during BUSY, in DONE against a handshake, and in IDLE against a request
      flush_busy(0, 19);
      issue(0, OP_REMU, 48'd77, 48'd0, 5'd4);
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      chk("fd_valid_pre", 64'(resp_valid[0]), 64'd1);
      resp_ready[0] = 1'b1;
      flush[0] = 1'b1;
      #1 chk("fd_ready", 64'(req_ready[0]), 64'd0);
      @(posedge clk); #1;
      resp_ready[0] = 1'b0;
      flush[0] = 1'b0;
      chk("fd_valid", 64'(resp_valid[0]), 64'd0);
      chk("fd_busy", 64'(busy[0]), 64'd0);
      flush[0] = 1'b1;
      issue(0, OP_DIVU, 48'd9, 48'd0, 5'd2);
      #1 chk("fi_ready", 64'(req_ready[0]), 64'd0);
      @(posedge clk); #1;
      flush[0] = 1'b0;
      req_valid[0] = 1'b0;
      chk("fi_busy", 64'(busy[0]), 64'd0);
      chk("fi_valid", 64'(resp_valid[0]), 64'd0);
      run_op(0, OP_REM, 48'd100, 48'hFFFF_FFFF_FFFD, 5'd1);

      // Random ops against the model
      for (int i = 0; i < 40; i++) begin
         op = muldiv_op_e'(3'($urandom_range(0, 7)));
         a  = rnd_opnd();
         b  = rnd_opnd();
         run_op(0, op, a, b, 5'($urandom()));
      end

      // Four bits per cycle instance
      run_op(1, OP_DIVU, 48'd100, 48'd7, 5'd3);
      run_op(1, OP_MULH, 48'hFFFF_FFFF_FFF9, 48'd6, 5'd17);
      flush_busy(1, 5);
      for (int i = 0; i < 20; i++) begin
         op = muldiv_op_e'(3'($urandom_range(0, 7)));
         a  = rnd_opnd();
         b  = rnd_opnd();
         run_op(1, op, a, b, 5'($urandom()));
      end

      // Asynchronous reset mid-operation: no partial result afterwards
      issue(0, OP_DIV, 48'h0123_4567_89AB, 48'd77, 5'd30);
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("mrst_valid", 64'(resp_valid[0]), 64'd0);
      chk("mrst_busy", 64'(busy[0]), 64'd0);
      chk("mrst_result", 64'(resp_result[0]), 64'd0);
      chk("mrst_tag", 64'(resp_tag[0]), 64'd0);
      chk("mrst_ready", 64'(req_ready[0]), 64'd1);
      @(negedge clk) rst_n = 1'b1;
      begin
         int seen;
         seen = 0;
         repeat (60) begin
            @(posedge clk); #1;
            if (resp_valid[0]) seen++;
         end
         chk("mrst_quiet", 64'(seen), 64'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
